key_extract: RTL and testbench

KEY_EXTRACT -- requirements
Module: key_extract

---
 rtl/key_extract_pkg.sv | 56 +++++
 rtl/key_extract.sv | 125 ++++++++++++
 tb/tb_key_extract.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_extract_pkg.sv
// Shared constants for the key extractor and the TCAM lookup stage:
// word tags, L3/L4 constants, key field offsets and parser state encoding.
package key_extract_pkg;

    localparam int TAG_MSB = 133;
    localparam int TAG_LSB = 132;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [7:0]  PROTO_TCP = 8'd6;
    localparam logic [7:0]  PROTO_UDP = 8'd17;

    localparam int KEY_W         = 104;
    localparam int KEY_SRC_LSB   = 72;
    localparam int KEY_DST_LSB   = 40;
    localparam int KEY_SPORT_LSB = 24;
    localparam int KEY_DPORT_LSB = 8;
    localparam int KEY_PROTO_LSB = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_W1   = 3'd1;
    localparam logic [2:0] ST_W2   = 3'd2;
    localparam logic [2:0] ST_W3   = 3'd3;
    localparam logic [2:0] ST_BODY = 3'd4;

    typedef struct packed {
        logic [15:0] ethertype;
        logic [7:0]  proto;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] sport;
        logic [15:0] dport;
    } fields_t;

    // Non-IPv4 frames yield an all-zero key; ports only count for TCP/UDP.
    function automatic logic [KEY_W-1:0] build_key(input fields_t f);
        logic [KEY_W-1:0] k;
        logic             has_ports;
        k         = '0;
        has_ports = (f.proto == PROTO_TCP) || (f.proto == PROTO_UDP);
        if (f.ethertype == ETH_IPV4) begin
            k[KEY_SRC_LSB   +: 32] = f.src_ip;
            k[KEY_DST_LSB   +: 32] = f.dst_ip;
            k[KEY_PROTO_LSB +: 8]  = f.proto;
            if (has_ports) begin
                k[KEY_SPORT_LSB +: 16] = f.sport;
                k[KEY_DPORT_LSB +: 16] = f.dport;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/key_extract.sv
// Parses the first four words of each packet into a 5-tuple lookup key while
// forwarding every accepted word unchanged one cycle later.
module key_extract
    import key_extract_pkg::*;
#(
    parameter int w_pkt = 134,
    parameter int w_key = 104
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_in_valid,
    input  logic [w_pkt-1:0] pkt_in,
    output logic             pkt_in_ready,
    output logic             pkt_out_valid,
    output logic [w_pkt-1:0] pkt_out,
    input  logic             pkt_out_ready,
    output logic             key_valid,
    output logic [w_key-1:0] key,
    input  logic             key_ready,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      err_cnt
);

    logic [2:0]       state_q, state_d;
    fields_t          fields_q, fields_d;
    logic             pkt_in_ready_q;
    logic             pkt_out_valid_q;
    logic [w_pkt-1:0] pkt_out_q;
    logic             key_valid_q;
    logic [w_key-1:0] key_q;
    logic [31:0]      pkt_cnt_q;
    logic [31:0]      err_cnt_q;

    logic       accept;
    logic [1:0] tag;
    logic       is_head;
    logic       is_tail;
    logic       emit;
    logic       err_inc;

    assign accept  = pkt_in_valid && pkt_in_ready_q;
    assign tag     = pkt_in[TAG_MSB:TAG_LSB];
    assign is_head = (tag == TAG_HEAD);
    assign is_tail = (tag == TAG_TAIL);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d  = state_q;
        fields_d = fields_q;
        emit     = 1'b0;
        err_inc  = 1'b0;
        if (accept) begin
            if (is_head) begin
                // A head anywhere but IDLE aborts the packet in flight.
                fields_d = '0;
                state_d  = ST_W1;
                err_inc  = (state_q != ST_IDLE);
            end else begin
                case (state_q)
                    ST_IDLE: err_inc = 1'b1;
                    ST_W1: begin
                        fields_d.ethertype = pkt_in[31:16];
                        emit    = is_tail;
                        state_d = is_tail ? ST_IDLE : ST_W2;
                    end
                    ST_W2: begin
                        fields_d.proto          = pkt_in[71:64];
                        fields_d.src_ip         = pkt_in[47:16];
                        fields_d.dst_ip[31:16]  = pkt_in[15:0];
                        emit    = is_tail;
                        state_d = is_tail ? ST_IDLE : ST_W3;
                    end
                    ST_W3: begin
                        fields_d.dst_ip[15:0] = pkt_in[127:112];
                        fields_d.sport        = pkt_in[111:96];
                        fields_d.dport        = pkt_in[95:80];
                        emit    = 1'b1;
                        state_d = is_tail ? ST_IDLE : ST_BODY;
                    end
                    ST_BODY: begin
                        if (is_tail) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: capture registers are reset too, so a packet cut by reset leaves nothing behind.
            state_q         <= ST_IDLE;
            fields_q        <= '0;
            pkt_in_ready_q  <= 1'b0;
            pkt_out_valid_q <= 1'b0;
            pkt_out_q       <= '0;
            key_valid_q     <= 1'b0;
            key_q           <= '0;
            pkt_cnt_q       <= '0;
            err_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            fields_q        <= fields_d;
            pkt_in_ready_q  <= key_ready && pkt_out_ready;
            pkt_out_valid_q <= accept;
            key_valid_q     <= emit;
            if (accept) pkt_out_q <= pkt_in;
            if (emit) begin
                key_q     <= w_key'(build_key(fields_d));
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (err_inc) err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign pkt_in_ready  = pkt_in_ready_q;
    assign pkt_out_valid = pkt_out_valid_q;
    assign pkt_out       = pkt_out_q;
    assign key_valid     = key_valid_q;
    assign key           = key_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_key_extract.sv
// Randomised scoreboard bench for key_extract: a packet-level reference model
// predicts forwarded words and keys; a monitor compares whatever the DUT emits.
module tb_key_extract;

    localparam int W_PKT = 134;
    localparam int W_KEY = 104;

    logic             clk = 1'b0;
    logic             reset;
    logic             pkt_in_valid;
    logic [W_PKT-1:0] pkt_in;
    logic             pkt_in_ready;
    logic             pkt_out_valid;
    logic [W_PKT-1:0] pkt_out;
    logic             pkt_out_ready;
    logic             key_valid;
    logic [W_KEY-1:0] key;
    logic             key_ready;
    logic [31:0]      pkt_cnt;
    logic [31:0]      err_cnt;

    always #5 clk = ~clk;

    key_extract #(.w_pkt(W_PKT), .w_key(W_KEY)) dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in        (pkt_in),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out       (pkt_out),
        .pkt_out_ready (pkt_out_ready),
        .key_valid     (key_valid),
        .key           (key),
        .key_ready     (key_ready),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W_PKT-1:0] act, input logic [W_PKT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- reference model ----------------
    logic [W_PKT-1:0] exp_words[$];
    logic [W_KEY-1:0] exp_keys[$];
    logic [127:0]     wbuf[4];
    int               nw;
    bit               open_pkt;
    bit               key_done;
    int               pkt_exp;
    int               err_exp;

    function automatic logic [W_KEY-1:0] ref_key();
        logic [15:0] eth;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] sp;
        logic [15:0] dp;
        eth   = wbuf[1][31:16];
        proto = wbuf[2][71:64];
        src   = wbuf[2][47:16];
        dst   = {wbuf[2][15:0], wbuf[3][127:112]};
        sp    = wbuf[3][111:96];
        dp    = wbuf[3][95:80];
        if (eth != 16'h0800) return '0;
        if (!(proto == 8'd6 || proto == 8'd17)) begin
            sp = '0;
            dp = '0;
        end
        return {src, dst, sp, dp, proto};
    endfunction

    task automatic model_accept(input logic [W_PKT-1:0] w);
        logic [1:0] t;
        t = w[133:132];
        exp_words.push_back(w);
        if (t == 2'b01) begin
            if (open_pkt) err_exp++;
            open_pkt = 1;
            nw       = 1;
            key_done = 0;
            for (int i = 0; i < 4; i++) wbuf[i] = '0;
        end else if (!open_pkt) begin
            err_exp++;
        end else begin
            if (nw < 4) wbuf[nw] = w[127:0];
            nw++;
            if (!key_done && (nw == 4 || t == 2'b10)) begin
                exp_keys.push_back(ref_key());
                key_done = 1;
                pkt_exp++;
            end
            if (t == 2'b10) open_pkt = 0;
        end
    endtask

    task automatic model_reset();
        open_pkt = 0;
        nw       = 0;
        key_done = 0;
        pkt_exp  = 0;
        err_exp  = 0;
        exp_words.delete();
        exp_keys.delete();
    endtask

    // ---------------- monitor ----------------
    logic [W_KEY-1:0] last_key = '0;
    int               keys_seen = 0;
    logic             ready_model;

    always @(posedge clk or negedge reset) begin
        if (!reset) ready_model <= 1'b0;
        else        ready_model <= key_ready && pkt_out_ready;
    end

    always @(negedge clk) begin
        if (!reset) begin
            keys_seen = 0;
        end else begin
            check("pkt_in_ready", W_PKT'(pkt_in_ready), W_PKT'(ready_model));
            if (pkt_out_valid) begin
                if (exp_words.size() == 0) fail_now("pkt_out_extra", $sformatf("got %h, expected no word", pkt_out));
                else check("pkt_out", pkt_out, exp_words.pop_front());
            end
            if (key_valid) begin
                keys_seen++;
                last_key = key;
                check("pkt_cnt_at_key", W_PKT'(pkt_cnt), W_PKT'(keys_seen));
                if (exp_keys.size() == 0) fail_now("key_extra", $sformatf("got %h, expected no key", key));
                else check("key", W_PKT'(key), W_PKT'(exp_keys.pop_front()));
            end
        end
    end

    // ---------------- back-pressure driver ----------------
    bit bp_en    = 0;
    bit hold_low = 0;
    bit gaps_en  = 0;

    always @(negedge clk) begin
        #1;
        if (hold_low) begin
            key_ready     = 1'b0;
            pkt_out_ready = 1'b1;
        end else if (bp_en) begin
            key_ready     = ($urandom_range(3) != 0);
            pkt_out_ready = ($urandom_range(3) != 0);
        end else begin
            key_ready     = 1'b1;
            pkt_out_ready = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_word(input logic [1:0] t, input logic [127:0] data);
        logic [W_PKT-1:0] w;
        int               waited;
        w            = {t, 4'($urandom), data};
        pkt_in       = w;
        pkt_in_valid = 1'b1;
        waited       = 0;
        while (!pkt_in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!pkt_in_ready) begin
            fail_now("accept_timeout", "pkt_in_ready stayed low for 200 cycles");
            pkt_in_valid = 1'b0;
            return;
        end
        model_accept(w);
        @(negedge clk);
        pkt_in_valid = 1'b0;
        if (gaps_en && $urandom_range(3) == 0) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [15:0] eth, input logic [7:0] proto,
                            input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] sp, input logic [15:0] dp,
                            input int nwords, input bit truncate);
        logic [127:0] d;
        logic [1:0]   t;
        for (int i = 0; i < nwords; i++) begin
            d = rnd128();
            if (i == 1) d[31:16] = eth;
            if (i == 2) begin
                d[71:64] = proto;
                d[47:16] = src;
                d[15:0]  = dst[31:16];
            end
            if (i == 3) begin
                d[127:112] = dst[15:0];
                d[111:96]  = sp;
                d[95:80]   = dp;
            end
            if (i == 0)                           t = 2'b01;
            else if (i == nwords - 1 && !truncate) t = 2'b10;
            else                                  t = 2'b11;
            send_word(t, d);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        repeat (3) @(negedge clk);
        while ((exp_words.size() != 0 || exp_keys.size() != 0) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (exp_words.size() != 0 || exp_keys.size() != 0) begin
            fail_now("drain", $sformatf("%0d words and %0d keys never appeared", exp_words.size(), exp_keys.size()));
            exp_words.delete();
            exp_keys.delete();
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] eth;
        logic [7:0]  proto;
        int          r;

        reset        = 1'b0;
        pkt_in_valid = 1'b0;
        pkt_in       = '0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_pkt_in_ready",  W_PKT'(pkt_in_ready),  '0);
        check("rst_pkt_out_valid", W_PKT'(pkt_out_valid), '0);
        check("rst_pkt_out",       pkt_out,               '0);
        check("rst_key_valid",     W_PKT'(key_valid),     '0);
        check("rst_key",           W_PKT'(key),           '0);
        check("rst_pkt_cnt",       W_PKT'(pkt_cnt),       '0);
        check("rst_err_cnt",       W_PKT'(err_cnt),       '0);

        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Packet cut by reset after its W2 word: nothing may come of it.
        send_word(2'b01, rnd128());
        send_word(2'b11, {96'h0, 16'h0800, 16'h0});
        send_word(2'b11, rnd128());
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("mid_reset_pkt_cnt", W_PKT'(pkt_cnt), '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        send_pkt(16'h0800, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 5, 0);
        wait_drain();
        check("tcp_key",     W_PKT'(last_key), W_PKT'(104'h0A000001_0A000002_04D2_0050_06));
        check("tcp_pkt_cnt", W_PKT'(pkt_cnt),  W_PKT'(32'd1));

        send_pkt(16'h0806, 8'd6, 32'h0A000003, 32'h0A000004, 16'd7, 16'd8, 5, 0);
        wait_drain();
        check("arp_key",     W_PKT'(last_key), '0);
        check("arp_pkt_cnt", W_PKT'(pkt_cnt),  W_PKT'(32'd2));

        send_pkt(16'h0800, 8'd1, 32'hC0A80101, 32'hC0A80202, 16'd1111, 16'd2222, 5, 0);
        wait_drain();
        check("icmp_key", W_PKT'(last_key), W_PKT'({32'hC0A80101, 32'hC0A80202, 32'h0, 8'd1}));

        send_pkt(16'h0800, 8'd6, 32'hAC100001, 32'hAC100002, 16'd99, 16'd443, 3, 0);
        wait_drain();
        check("short_key",     W_PKT'(last_key), W_PKT'({32'hAC100001, 16'hAC10, 16'h0, 32'h0, 8'd6}));
        check("short_pkt_cnt", W_PKT'(pkt_cnt),  W_PKT'(32'd4));

        // Truncated packet left in BODY, then a fresh head aborts it.
        send_pkt(16'h0800, 8'd6, 32'h01020304, 32'h05060708, 16'd10, 16'd20, 6, 1);
        send_pkt(16'h0800, 8'd17, 32'h05060708, 32'h090A0B0C, 16'd53, 16'd5353, 4, 0);
        wait_drain();
        check("abort_err_cnt", W_PKT'(err_cnt),  W_PKT'(32'd1));
        check("abort_pkt_cnt", W_PKT'(pkt_cnt),  W_PKT'(32'd6));
        check("abort_key",     W_PKT'(last_key), W_PKT'({32'h05060708, 32'h090A0B0C, 16'd53, 16'd5353, 8'd17}));

        // key_ready held low for 10 cycles while a packet is being offered.
        fork
            send_pkt(16'h0800, 8'd17, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'd1, 16'd2, 6, 0);
            begin
                hold_low = 1;
                @(negedge clk);
                repeat (10) begin
                    @(negedge clk);
                    check("hold_ready_low", W_PKT'(pkt_in_ready), '0);
                end
                hold_low = 0;
            end
        join
        wait_drain();
        check("hold_pkt_cnt", W_PKT'(pkt_cnt), W_PKT'(32'd7));

        bp_en   = 1;
        gaps_en = 1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(9);
            if (r == 0) begin
                send_word(($urandom_range(1) == 0) ? 2'b10 : 2'b11, rnd128());
            end else begin
                eth = ($urandom_range(4) == 0) ? 16'h0806 : 16'h0800;
                case ($urandom_range(3))
                    0:       proto = 8'd6;
                    1:       proto = 8'd17;
                    2:       proto = 8'd1;
                    default: proto = 8'($urandom);
                endcase
                send_pkt(eth, proto, $urandom, $urandom, 16'($urandom), 16'($urandom),
                         $urandom_range(2, 8), ($urandom_range(7) == 0));
            end
        end
        bp_en   = 0;
        gaps_en = 0;
        wait_drain();
        check("final_pkt_cnt", W_PKT'(pkt_cnt), W_PKT'(32'(pkt_exp)));
        check("final_err_cnt", W_PKT'(err_cnt), W_PKT'(32'(err_exp)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
